// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths and the EX/WB bundle layout
// {reg_write, data, rd} used by both the EX/WB register and the writeback stage.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int WB_BUS_W = 12;

    localparam int WE_BIT   = 11;
    localparam int DATA_MSB = 10;
    localparam int DATA_LSB = 3;
    localparam int RD_MSB   = 2;
    localparam int RD_LSB   = 0;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
    } wb_bundle_t;

    function automatic wb_bundle_t wb_unpack(input logic [WB_BUS_W-1:0] bus);
        wb_bundle_t b;
        b.we   = bus[WE_BIT];
        b.data = bus[DATA_MSB:DATA_LSB];
        b.rd   = bus[RD_MSB:RD_LSB];
        return b;
    endfunction

endpackage

// File: rtl/wb_read_port.sv
// One combinational register-file read port. With WB_BYPASS_EN defined the
// port forwards the in-flight writeback data when it targets the read address.
module wb_read_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic [(DATA_W << ADDR_W)-1:0] regs_flat,
    input  logic [ADDR_W-1:0]             addr,
`ifdef WB_BYPASS_EN
    input  logic                          wb_we,
    input  logic [ADDR_W-1:0]             wb_rd,
    input  logic [DATA_W-1:0]             wb_data,
`endif
    output logic [DATA_W-1:0]             rd_data
);

    logic [DATA_W-1:0] stored;

    assign stored = regs_flat[addr * DATA_W +: DATA_W];

`ifdef WB_BYPASS_EN
    logic hit;

    // Forwarding closes the same-cycle write/read hazard without a bubble.
    assign hit = wb_we && (wb_rd == addr);

    always_comb begin
        rd_data = stored;
        if (hit) begin
            rd_data = wb_data;
        end
    end
`else
    assign rd_data = stored;
`endif

endmodule

// File: rtl/wb_reg_file.sv
// Writeback stage + 8x8 architectural register file with two combinational
// read ports and a commit trace. Optional same-cycle forwarding: WB_BYPASS_EN.
module wb_reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [cpu_pkg::WB_BUS_W-1:0] wb_bus,
    input  logic [ADDR_W-1:0]            rs1_addr,
    input  logic [ADDR_W-1:0]            rs2_addr,
    output logic [DATA_W-1:0]            rs1_data,
    output logic [DATA_W-1:0]            rs2_data,
    output logic                         commit_valid,
    output logic [ADDR_W-1:0]            commit_rd,
    output logic [CNT_W-1:0]             commit_count
);

    import cpu_pkg::*;

    localparam int NREG = 1 << ADDR_W;

    // There is no valid/ready handshake: every bundle with reg_write set is
    // accepted on the edge it is presented, so the stage never stalls.
    logic              wb_we;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_rd;

    assign wb_we   = wb_bus[WE_BIT];
    assign wb_data = wb_bus[DATA_MSB:DATA_LSB];
    assign wb_rd   = wb_bus[RD_MSB:RD_LSB];

    logic [NREG-1:0][DATA_W-1:0] regs;

    // Reset wins over a simultaneous commit: the write is dropped and uncounted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs <= '0;
        end else if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_count <= '0;
        end else begin
            commit_valid <= wb_we;
            if (wb_we) begin
                commit_rd    <= wb_rd;
                commit_count <= commit_count + CNT_W'(1);
            end
        end
    end

    wb_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs1 (
        .regs_flat (regs),
        .addr      (rs1_addr),
`ifdef WB_BYPASS_EN
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
`endif
        .rd_data   (rs1_data)
    );

    wb_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs2 (
        .regs_flat (regs),
        .addr      (rs2_addr),
`ifdef WB_BYPASS_EN
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
`endif
        .rd_data   (rs2_data)
    );

endmodule

// File: tb/tb_wb_reg_file.sv
// Bench for wb_reg_file: array-based reference model, per-cycle compare,
// directed literal cases, counter wrap and randomized traffic.
module tb_wb_reg_file;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] wb_bus = '0;
    logic [2:0]  rs1_addr = '0;
    logic [2:0]  rs2_addr = '0;
    logic [7:0]  rs1_data;
    logic [7:0]  rs2_data;
    logic        commit_valid;
    logic [2:0]  commit_rd;
    logic [15:0] commit_count;

    wb_reg_file dut (
        .clk          (clk),
        .reset        (reset),
        .wb_bus       (wb_bus),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_count (commit_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];

    int  m_regs[8];
    int  m_count = 0;
    int  m_rd = 0;
    bit  m_valid = 1'b0;
    bit  m_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_read(input logic [2:0] a);
`ifdef WB_BYPASS_EN
        if (wb_bus[11] && wb_bus[2:0] == a) return int'(wb_bus[10:3]);
`endif
        return m_regs[a];
    endfunction

    // Reference model: architectural state after each rising edge.
    always @(posedge clk) begin
        if (!reset) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_count = 0;
            m_rd    = 0;
            m_valid = 1'b0;
            m_known = 1'b1;
        end else begin
            m_valid = wb_bus[11];
            if (wb_bus[11]) begin
                m_regs[wb_bus[2:0]] = int'(wb_bus[10:3]);
                m_count = (m_count + 1) % 65536;
                m_rd    = int'(wb_bus[2:0]);
            end
        end
    end

    // Compare process: every cycle once the model state is defined.
    always @(negedge clk) begin
        if (m_known) begin
            check("rs1_data", 32'(rs1_data), 32'(exp_read(rs1_addr)));
            check("rs2_data", 32'(rs2_data), 32'(exp_read(rs2_addr)));
            check("commit_valid", 32'(commit_valid), 32'(m_valid));
            check("commit_rd", 32'(commit_rd), 32'(m_rd));
            check("commit_count", 32'(commit_count), 32'(m_count));
            if (exp_q.size() > 0) check("rs1_literal", 32'(rs1_data), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic r, input logic [11:0] bus,
                          input logic [2:0] a1, input logic [2:0] a2);
        reset    = r;
        wb_bus   = bus;
        rs1_addr = a1;
        rs2_addr = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held two edges with an all-ones bundle on the bus.
        set_in(1'b0, 12'hFFF, 3'd0, 3'd0);
        tick();
        tick();
        set_in(1'b0, 12'h000, 3'd0, 3'd0);
        at_neg();
        for (int a = 0; a < 8; a++) begin
            rs1_addr = 3'(a);
            rs2_addr = 3'(7 - a);
            #1;
            check("reset_rs1", 32'(rs1_data), 32'h0);
            check("reset_rs2", 32'(rs2_data), 32'h0);
        end
        check("reset_count", 32'(commit_count), 32'h0);
        check("reset_valid", 32'(commit_valid), 32'h0);
        tick();

        // Basic write then read.
        set_in(1'b1, {1'b1, 8'hA5, 3'd2}, 3'd0, 3'd0);
        tick();
        set_in(1'b1, 12'h000, 3'd2, 3'd0);
        exp_q.push_back(8'hA5);
        at_neg();
        check("basic_count", 32'(commit_count), 32'd1);
        check("basic_rd", 32'(commit_rd), 32'd2);
        check("basic_valid", 32'(commit_valid), 32'd1);
        tick();

        // Same-cycle hazard on r5.
        set_in(1'b1, {1'b1, 8'h11, 3'd5}, 3'd0, 3'd5);
        tick();
        set_in(1'b1, {1'b1, 8'h3C, 3'd5}, 3'd0, 3'd5);
        at_neg();
`ifdef WB_BYPASS_EN
        check("hazard_same_cycle", 32'(rs2_data), 32'h3C);
`else
        check("hazard_same_cycle", 32'(rs2_data), 32'h11);
`endif
        tick();
        set_in(1'b1, 12'h000, 3'd0, 3'd5);
        at_neg();
        check("hazard_next_cycle", 32'(rs2_data), 32'h3C);
        tick();

        // Bundle with reg_write clear is a no-op.
        set_in(1'b1, {1'b0, 8'hFF, 3'd1}, 3'd1, 3'd0);
        tick();
        at_neg();
        check("nowrite_r1", 32'(rs1_data), 32'h0);
        check("nowrite_count", 32'(commit_count), 32'd3);
        check("nowrite_valid", 32'(commit_valid), 32'd0);
        tick();

        // Reset on the same edge as a commit drops the commit.
        set_in(1'b1, {1'b1, 8'h99, 3'd4}, 3'd4, 3'd0);
        tick();
        set_in(1'b0, {1'b1, 8'h77, 3'd4}, 3'd4, 3'd0);
        tick();
        set_in(1'b1, 12'h000, 3'd4, 3'd0);
        at_neg();
        check("midreset_r4", 32'(rs1_data), 32'h0);
        check("midreset_count", 32'(commit_count), 32'd0);
        tick();

        // Counter wrap: 65536 commits return to zero, one more gives one.
        for (int i = 0; i < 65536; i++) begin
            set_in(1'b1, {1'b1, 8'($urandom), 3'($urandom)}, 3'($urandom), 3'($urandom));
            tick();
        end
        set_in(1'b1, 12'h000, 3'd0, 3'd0);
        at_neg();
        check("wrap_zero", 32'(commit_count), 32'd0);
        tick();
        set_in(1'b1, {1'b1, 8'h5A, 3'd6}, 3'd6, 3'd6);
        tick();
        set_in(1'b1, 12'h000, 3'd6, 3'd0);
        exp_q.push_back(8'h5A);
        at_neg();
        check("wrap_one", 32'(commit_count), 32'd1);
        tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 39) != 0),
                   {1'($urandom), 8'($urandom), 3'($urandom)},
                   3'($urandom), 3'($urandom));
            tick();
        end
        set_in(1'b1, 12'h000, 3'd0, 3'd0);
        tick();
        at_neg();

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
